// File: rtl/codec_intf.sv
`default_nettype none
// codec_intf: derives MCLK/SCLK/LRCLK from clk and moves I2S data between the codec and the core.
// Rev 1.0. Incoming words appear as a parallel left/right pair with a valid strobe; outgoing pairs are serialised onto SDin.
module codec_intf (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] lft_out,
  input  logic [15:0] rht_out,
  input  logic        SDout,
  output logic        MCLK,
  output logic        SCLK,
  output logic        LRCLK,
  output logic        RSTn,
  output logic        SDin,
  output logic [15:0] lft_in,
  output logic [15:0] rht_in,
  output logic        valid
);

  logic [9:0]  cnt;
  logic [9:0]  cnt_nxt;
  logic [1:0]  frm_cnt;
  logic [15:0] lft_sr;
  logic [15:0] rht_sr;
  logic [15:0] lft_shadow;
  logic [15:0] tx_lft;
  logic [15:0] tx_rht;
  logic [4:0]  slot;
  logic [4:0]  slot_nxt;
  logic [3:0]  bit_idx;
  logic        in_word;
  logic        in_word_nxt;
  logic        tx_bit;

  assign cnt_nxt     = cnt + 10'd1;
  assign slot        = cnt[8:4];
  assign slot_nxt    = cnt_nxt[8:4];
  assign in_word     = (slot >= 5'd1) && (slot <= 5'd16);
  assign in_word_nxt = (slot_nxt >= 5'd1) && (slot_nxt <= 5'd16);
  // Slot s carries bit 16-s; modulo 16 that is simply -s.
  assign bit_idx     = 4'd0 - slot_nxt[3:0];
  assign tx_bit      = cnt_nxt[9] ? tx_rht[bit_idx] : tx_lft[bit_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      frm_cnt    <= '0;
      MCLK       <= 1'b0;
      SCLK       <= 1'b0;
      LRCLK      <= 1'b0;
      RSTn       <= 1'b0;
      SDin       <= 1'b0;
      lft_in     <= '0;
      rht_in     <= '0;
      valid      <= 1'b0;
      lft_sr     <= '0;
      rht_sr     <= '0;
      lft_shadow <= '0;
      tx_lft     <= '0;
      tx_rht     <= '0;
    end else begin
      cnt   <= cnt_nxt;
      // Clock outputs track the counter value being loaded, so they equal the cnt bits cycle for cycle.
      MCLK  <= cnt_nxt[1];
      SCLK  <= cnt_nxt[3];
      LRCLK <= cnt_nxt[9];
      RSTn  <= 1'b1;

      if ((cnt[3:0] == 4'b0111) && in_word) begin
        if (cnt[9]) rht_sr <= {rht_sr[14:0], SDout};
        else        lft_sr <= {lft_sr[14:0], SDout};
      end

      if (cnt == 10'h108) lft_shadow <= lft_sr;

      if (cnt == 10'h308) begin
        lft_in <= lft_shadow;
        rht_in <= rht_sr;
      end
      valid <= (cnt == 10'h308) && frm_cnt[1];

      if (cnt == 10'h3FF) begin
        tx_lft <= lft_out;
        tx_rht <= rht_out;
        if (frm_cnt != 2'd3) frm_cnt <= frm_cnt + 2'd1;
      end

      if (cnt[3:0] == 4'b1111) SDin <= in_word_nxt ? tx_bit : 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_codec_intf.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for codec_intf: I2S codec model plus frame-level reference model.
module tb_codec_intf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] lft_out = '0;
  logic [15:0] rht_out = '0;
  logic        SDout = 1'b0;
  logic        MCLK, SCLK, LRCLK, RSTn, SDin, valid;
  logic [15:0] lft_in, rht_in;

  int          tests = 0;
  int          fails = 0;
  int unsigned abs_clk = 0;
  logic [15:0] rx_l [64];
  logic [15:0] rx_r [64];
  bit          glitch_en = 1'b0;
  bit          filler_one = 1'b0;

  codec_intf dut (
    .clk(clk), .rst(rst), .lft_out(lft_out), .rht_out(rht_out), .SDout(SDout),
    .MCLK(MCLK), .SCLK(SCLK), .LRCLK(LRCLK), .RSTn(RSTn), .SDin(SDin),
    .lft_in(lft_in), .rht_in(rht_in), .valid(valid)
  );

  always #10 clk = ~clk;

  // Clocks elapsed since reset release; equals the frame position the codec sees.
  always @(posedge clk) begin
    if (rst) abs_clk <= 0;
    else     abs_clk <= abs_clk + 1;
  end

  // Codec ADC model: I2S words in slots 1..16, filler elsewhere, optional glitches off the sampling edge.
  initial begin : codec_adc
    int pos, fr, sl;
    logic [15:0] w;
    forever begin
      @(negedge clk);
      pos = int'(abs_clk % 1024);
      fr  = int'(abs_clk / 1024) % 64;
      sl  = (pos % 512) / 16;
      if (sl >= 1 && sl <= 16) begin
        w = (pos >= 512) ? rx_r[fr] : rx_l[fr];
        if (glitch_en && (pos % 16 != 7)) SDout = 1'($urandom % 2);
        else                              SDout = w[16 - sl];
      end else begin
        SDout = filler_one ? 1'b1 : (glitch_en ? 1'($urandom % 2) : 1'b0);
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      tests++;
      if ({MCLK, SCLK, LRCLK, RSTn, SDin, valid} !== 6'b0 || lft_in !== 16'h0 || rht_in !== 16'h0) begin
        fails++;
        $display("FAIL reset_state: got clocks/RSTn/SDin/valid=%b lft_in=%h rht_in=%h, want all zero",
                 {MCLK, SCLK, LRCLK, RSTn, SDin, valid}, lft_in, rht_in);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      tests++;
      if (RSTn !== 1'b1 || MCLK !== abs_clk[1] || SCLK !== abs_clk[3] || LRCLK !== abs_clk[9]) begin
        fails++;
        $display("FAIL clocks at clk %0d: got RSTn/MCLK/SCLK/LRCLK=%b%b%b%b, want 1%b%b%b",
                 abs_clk, RSTn, MCLK, SCLK, LRCLK, abs_clk[1], abs_clk[3], abs_clk[9]);
      end
    end
  endtask

  task automatic test_receive();
    logic [15:0] hl, hr;
    logic        ev;
    int          fr;
    for (int f = 0; f < 64; f++) begin
      rx_l[f] = (f < 5) ? 16'h8001 : 16'($urandom);
      rx_r[f] = (f < 5) ? 16'h7FFE : 16'($urandom);
    end
    glitch_en = 1'b1; filler_one = 1'b0;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    hl = '0; hr = '0;
    for (int i = 0; i < 10 * 1024; i++) begin
      @(negedge clk);
      fr = int'(abs_clk / 1024) % 64;
      ev = (abs_clk >= 2048) && (abs_clk % 1024 == 777);
      if (abs_clk % 1024 == 777) begin hl = rx_l[fr]; hr = rx_r[fr]; end
      tests++;
      if (valid !== ev) begin
        fails++;
        $display("FAIL rx_valid at clk %0d: got %b, want %b", abs_clk, valid, ev);
      end
      tests++;
      if (lft_in !== hl || rht_in !== hr) begin
        fails++;
        $display("FAIL rx_data at clk %0d: got %h/%h, want %h/%h", abs_clk, lft_in, rht_in, hl, hr);
      end
    end
    // Reset landing on a valid cycle must clear the strobe on the next edge.
    for (int i = 0; i < 1100 && !((abs_clk % 1024) == 777); i++) @(negedge clk);
    tests++;
    if (valid !== 1'b1) begin
      fails++;
      $display("FAIL rx_valid_before_rst: got %b, want 1", valid);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (valid !== 1'b0 || lft_in !== 16'h0) begin
      fails++;
      $display("FAIL rst_on_valid: got valid=%b lft_in=%h, want 0/0000", valid, lft_in);
    end
    rst = 1'b0;
  endtask

  task automatic test_transmit();
    logic [15:0] lat_l [64];
    logic [15:0] lat_r [64];
    logic [15:0] w;
    logic        eb, prev;
    int          pos, fr, sl;
    lft_out = 16'hA5C3; rht_out = 16'h0F0F;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    lat_l[0] = '0; lat_r[0] = '0; prev = 1'b0;
    for (int i = 0; i < 6 * 1024; i++) begin
      @(negedge clk);
      pos = int'(abs_clk % 1024);
      fr  = int'(abs_clk / 1024);
      sl  = (pos % 512) / 16;
      w   = (pos >= 512) ? lat_r[fr] : lat_l[fr];
      eb  = (sl >= 1 && sl <= 16) ? w[16 - sl] : 1'b0;
      tests++;
      if (SDin !== eb) begin
        fails++;
        $display("FAIL tx_bit at clk %0d slot %0d: got %b, want %b", abs_clk, sl, SDin, eb);
      end
      tests++;
      if (SDin !== prev && (abs_clk % 16) != 0) begin
        fails++;
        $display("FAIL tx_edge at clk %0d: got change off SCLK fall, want change only when clk%%16==0", abs_clk);
      end
      prev = SDin;
      if (pos == 1023) begin lat_l[fr + 1] = lft_out; lat_r[fr + 1] = rht_out; end
      if (pos == 512 && fr >= 2) begin lft_out = 16'($urandom); rht_out = 16'($urandom); end
    end
  endtask

  task automatic test_loopback();
    logic [15:0] base_l, base_r, step, dl, dr, el, er;
    int          pos, fr, sl;
    base_l = 16'($urandom); base_r = 16'($urandom); step = 16'($urandom_range(1, 255));
    for (int f = 0; f < 64; f++) begin
      rx_l[f] = 16'(base_l + f * step);
      rx_r[f] = 16'(base_r - f * step);
    end
    glitch_en = 1'b1; filler_one = 1'b0;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    dl = '0; dr = '0;
    for (int i = 0; i < 10 * 1024; i++) begin
      @(negedge clk);
      lft_out = lft_in; rht_out = rht_in;
      pos = int'(abs_clk % 1024);
      fr  = int'(abs_clk / 1024);
      sl  = (pos % 512) / 16;
      if (sl >= 1 && sl <= 16 && (pos % 16) == 8) begin
        if (pos >= 512) dr = {dr[14:0], SDin};
        else            dl = {dl[14:0], SDin};
      end
      // Core is a passthrough, so each ramp sample returns exactly one frame later.
      el = (fr == 0) ? 16'h0 : rx_l[fr - 1];
      er = (fr == 0) ? 16'h0 : rx_r[fr - 1];
      if (pos == 272) begin
        tests++;
        if (dl !== el) begin
          fails++;
          $display("FAIL loop_left frame %0d: got %h, want %h", fr, dl, el);
        end
      end
      if (pos == 784) begin
        tests++;
        if (dr !== er) begin
          fails++;
          $display("FAIL loop_right frame %0d: got %h, want %h", fr, dr, er);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] hl, hr;
    logic        ev;
    int          fr;
    for (int f = 0; f < 64; f++) begin rx_l[f] = 16'($urandom); rx_r[f] = 16'($urandom); end
    lft_out = 16'($urandom); rht_out = 16'($urandom);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5000 && abs_clk != 3 * 1024 + 'h250; i++) @(negedge clk);
    tests++;
    if (abs_clk != 3 * 1024 + 'h250) begin
      fails++;
      $display("FAIL mid_wait: got clk %0d, want %0d", abs_clk, 3 * 1024 + 'h250);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({MCLK, SCLK, LRCLK, RSTn, SDin, valid} !== 6'b0 || lft_in !== 16'h0 || rht_in !== 16'h0) begin
      fails++;
      $display("FAIL mid_reset_state: got %b lft_in=%h rht_in=%h, want all zero",
               {MCLK, SCLK, LRCLK, RSTn, SDin, valid}, lft_in, rht_in);
    end
    for (int f = 0; f < 64; f++) begin rx_l[f] = 16'($urandom); rx_r[f] = 16'($urandom); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hl = '0; hr = '0;
    for (int i = 0; i < 4 * 1024; i++) begin
      @(negedge clk);
      fr = int'(abs_clk / 1024) % 64;
      ev = (abs_clk >= 2048) && (abs_clk % 1024 == 777);
      if (abs_clk % 1024 == 777) begin hl = rx_l[fr]; hr = rx_r[fr]; end
      tests++;
      if (valid !== ev) begin
        fails++;
        $display("FAIL mid_valid at clk %0d: got %b, want %b", abs_clk, valid, ev);
      end
      if (ev) begin
        tests++;
        if (lft_in !== hl || rht_in !== hr) begin
          fails++;
          $display("FAIL mid_data at clk %0d: got %h/%h, want %h/%h", abs_clk, lft_in, rht_in, hl, hr);
        end
      end
    end
  endtask

  task automatic test_slot_isolation();
    for (int f = 0; f < 64; f++) begin rx_l[f] = '0; rx_r[f] = '0; end
    glitch_en = 1'b0; filler_one = 1'b1;
    repeat (1024) @(negedge clk);
    for (int i = 0; i < 3 * 1024; i++) begin
      @(negedge clk);
      if (abs_clk % 1024 == 777) begin
        tests++;
        if (valid !== 1'b1 || lft_in !== 16'h0 || rht_in !== 16'h0) begin
          fails++;
          $display("FAIL slot_isolation at clk %0d: got valid=%b %h/%h, want 1 0000/0000",
                   abs_clk, valid, lft_in, rht_in);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_receive();
    test_transmit();
    test_loopback();
    test_reset_mid();
    test_slot_isolation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
